// File: rtl/test_ram_arbiter.sv
// Two-port round-robin arbiter in front of the single-port test RAM.
// Each access runs IDLE -> ISSUE -> WAIT -> DONE, and WAIT gives up after TIMEOUT cycles.
module test_ram_arbiter #(
  parameter int ADDR_MSB = 15,
  parameter int DATA_MSB = 7,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [ADDR_MSB:0]   a_addr,
  input  logic [DATA_MSB:0]   a_wdata,
  output logic                a_ack,
  output logic                a_err,
  output logic [DATA_MSB:0]   a_rdata,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [ADDR_MSB:0]   b_addr,
  input  logic [DATA_MSB:0]   b_wdata,
  output logic                b_ack,
  output logic                b_err,
  output logic [DATA_MSB:0]   b_rdata,
  output logic                ram_we,
  output logic [ADDR_MSB:0]   ram_addr,
  output logic [DATA_MSB:0]   ram_data_in,
  input  logic [DATA_MSB:0]   ram_data_out,
  input  logic                ram_data_ready,
  output logic [1:0]          grant
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic       last_b;
  logic [7:0] cnt;
  logic       pick_a;
  logic       pick_b;

  // A wins unless B also requests and A was served last.
  always_comb begin
    pick_a = 1'b0;
    pick_b = 1'b0;
    if (a_req && (!b_req || last_b)) begin
      pick_a = 1'b1;
    end else if (b_req) begin
      pick_b = 1'b1;
    end else begin
      pick_a = 1'b0;
      pick_b = 1'b0;
    end
  end

  // Sequencer; every output is a register owned by this block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_b      <= 1'b1;
      cnt         <= 8'd0;
      grant       <= 2'b00;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_data_in <= '0;
      a_ack       <= 1'b0;
      a_err       <= 1'b0;
      a_rdata     <= '0;
      b_ack       <= 1'b0;
      b_err       <= 1'b0;
      b_rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_a) begin
            ram_we      <= a_we;
            ram_addr    <= a_addr;
            ram_data_in <= a_wdata;
            grant       <= 2'b01;
            last_b      <= 1'b0;
            state       <= ISSUE;
          end else if (pick_b) begin
            ram_we      <= b_we;
            ram_addr    <= b_addr;
            ram_data_in <= b_wdata;
            grant       <= 2'b10;
            last_b      <= 1'b1;
            state       <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          ram_we <= 1'b0;
          cnt    <= 8'd0;
          state  <= WAIT;
        end
        WAIT: begin
          // Read data is captured on writes too, so rdata reflects the RAM's reply.
          if (ram_data_ready) begin
            if (grant[0]) begin
              a_rdata <= ram_data_out;
              a_ack   <= 1'b1;
              a_err   <= 1'b0;
            end else begin
              b_rdata <= ram_data_out;
              b_ack   <= 1'b1;
              b_err   <= 1'b0;
            end
            state <= DONE;
          end else if (cnt == LAST_CNT) begin
            if (grant[0]) begin
              a_rdata <= '0;
              a_ack   <= 1'b1;
              a_err   <= 1'b1;
            end else begin
              b_rdata <= '0;
              b_ack   <= 1'b1;
              b_err   <= 1'b1;
            end
            state <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          a_ack <= 1'b0;
          a_err <= 1'b0;
          b_ack <= 1'b0;
          b_err <= 1'b0;
          grant <= 2'b00;
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          grant  <= 2'b00;
          ram_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test_ram_arbiter.sv
// Directed bench for test_ram_arbiter: a table of single accesses, round-robin, reset-abort.
// The RAM model answers after a programmable delay, never, or with ready forced high.
module tb_test_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [15:0] a_addr = 16'h0;
  logic [7:0]  a_wdata = 8'h0;
  logic        a_ack, a_err;
  logic [7:0]  a_rdata;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [15:0] b_addr = 16'h0;
  logic [7:0]  b_wdata = 8'h0;
  logic        b_ack, b_err;
  logic [7:0]  b_rdata;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data_in;
  logic [7:0]  ram_data_out;
  logic        ram_data_ready;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  // RAM model controls: mode 0 = ready after delay, 1 = never ready, 2 = always ready.
  int mode  = 0;
  int delay = 2;
  int gcnt  = 0;
  logic [7:0] mem [0:65535];

  test_ram_arbiter #(.ADDR_MSB(15), .DATA_MSB(7), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .ram_data_ready(ram_data_ready),
    .grant(grant)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data_in;
    if (grant == 2'b00) gcnt <= 0;
    else gcnt <= gcnt + 1;
  end

  assign ram_data_out   = mem[ram_addr];
  assign ram_data_ready = (mode == 2) || ((mode == 0) && (grant != 2'b00) && (gcnt >= delay - 1));

  typedef struct {
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          delay;
    int          mode;
    int          exp_k;
    bit          exp_err;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[8];
  logic [7:0] exp_a_rdata = 8'h00;
  logic [7:0] exp_b_rdata = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, {30'd0, grant}, 32'd0);
    check({tag, "_ram_we"}, {31'd0, ram_we}, 32'd0);
    check({tag, "_ram_addr"}, {16'd0, ram_addr}, 32'd0);
    check({tag, "_ram_data_in"}, {24'd0, ram_data_in}, 32'd0);
    check({tag, "_acks_errs"}, {28'd0, a_ack, a_err, b_ack, b_err}, 32'd0);
    check({tag, "_rdata"}, {16'd0, a_rdata, b_rdata}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  k;
    bit  got;
    int  we_cnt;
    bit  other_ack;
    @(negedge clk);
    mode  = v.mode;
    delay = v.delay;
    if (!v.port) begin
      a_req = 1'b1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
    end else begin
      b_req = 1'b1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata;
    end
    got = 1'b0; we_cnt = 0; other_ack = 1'b0; k = -1;
    for (int c = 0; c < 40 && !got; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        check($sformatf("v%0d_issue_addr", idx), {16'd0, ram_addr}, {16'd0, v.addr});
        check($sformatf("v%0d_issue_grant", idx), {30'd0, grant}, v.port ? 32'd2 : 32'd1);
        if (v.we) check($sformatf("v%0d_issue_data", idx), {24'd0, ram_data_in}, {24'd0, v.wdata});
      end
      if (ram_we) we_cnt++;
      if (v.port ? a_ack : b_ack) other_ack = 1'b1;
      if (v.port ? b_ack : a_ack) begin
        got = 1'b1;
        k = c;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    check($sformatf("v%0d_ack_latency", idx), k, v.exp_k);
    check($sformatf("v%0d_err", idx), {31'd0, v.port ? b_err : a_err}, {31'd0, v.exp_err});
    check($sformatf("v%0d_rdata", idx), {24'd0, v.port ? b_rdata : a_rdata}, {24'd0, v.exp_rdata});
    check($sformatf("v%0d_other_rdata", idx), {24'd0, v.port ? a_rdata : b_rdata},
          {24'd0, v.port ? exp_a_rdata : exp_b_rdata});
    check($sformatf("v%0d_we_pulses", idx), we_cnt, v.we ? 32'd1 : 32'd0);
    check($sformatf("v%0d_other_ack", idx), {31'd0, other_ack}, 32'd0);
    if (v.port) exp_b_rdata = v.exp_rdata;
    else exp_a_rdata = v.exp_rdata;
    @(posedge clk); #1;
    check($sformatf("v%0d_ack_drop", idx), {30'd0, a_ack, b_ack}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_a_rdata = 8'h00;
    exp_b_rdata = 8'h00;
  endtask

  initial begin
    int          a_cnt, b_cnt, n_gr, cyc;
    logic [1:0]  prev_grant;
    logic [1:0]  gr_port [8];
    logic [15:0] gr_addr [8];
    bit          got;

    //           port we  addr      wdata  dly mode k  err rdata
    vecs[0] = '{1'b0, 1'b1, 16'h0010, 8'h5A, 3, 0, 3, 1'b0, 8'h5A};
    vecs[1] = '{1'b1, 1'b0, 16'h0010, 8'h00, 2, 0, 2, 1'b0, 8'h5A};
    vecs[2] = '{1'b0, 1'b1, 16'h0020, 8'h77, 2, 0, 2, 1'b0, 8'h77};
    vecs[3] = '{1'b0, 1'b0, 16'h0020, 8'h00, 2, 1, 9, 1'b1, 8'h00};
    vecs[4] = '{1'b0, 1'b0, 16'h0020, 8'h00, 2, 0, 2, 1'b0, 8'h77};
    vecs[5] = '{1'b1, 1'b1, 16'h0030, 8'hC3, 4, 0, 4, 1'b0, 8'hC3};
    vecs[6] = '{1'b0, 1'b0, 16'h0030, 8'h00, 2, 2, 2, 1'b0, 8'hC3};
    vecs[7] = '{1'b1, 1'b0, 16'h0030, 8'h00, 2, 1, 9, 1'b1, 8'h00};

    #12;
    check_all_zero("reset");
    do_reset();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Both ports stream four reads each; grants must alternate starting with A.
    do_reset();
    @(negedge clk);
    mode = 0; delay = 2;
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0100;
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0200;
    a_cnt = 0; b_cnt = 0; n_gr = 0; cyc = 0;
    prev_grant = 2'b00;
    while ((a_cnt < 4 || b_cnt < 4) && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (prev_grant == 2'b00 && grant != 2'b00 && n_gr < 8) begin
        gr_port[n_gr] = grant;
        gr_addr[n_gr] = ram_addr;
        n_gr++;
      end
      prev_grant = grant;
      if (a_ack) begin
        a_cnt++;
        if (a_cnt == 4) a_req = 1'b0;
        else a_addr = 16'h0100 + 16'(a_cnt);
      end
      if (b_ack) begin
        b_cnt++;
        if (b_cnt == 4) b_req = 1'b0;
        else b_addr = 16'h0200 + 16'(b_cnt);
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    check("rr_grant_count", n_gr, 32'd8);
    for (int i = 0; i < n_gr; i++) begin
      check($sformatf("rr_grant_%0d", i), {30'd0, gr_port[i]}, (i % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("rr_addr_%0d", i), {16'd0, gr_addr[i]},
            (i % 2 == 0) ? 32'h0100 + 32'(i / 2) : 32'h0200 + 32'(i / 2));
    end

    // Reset in the middle of a B write's WAIT phase, then A beats the still-pending B.
    @(negedge clk);
    mode = 1;
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0040; b_wdata = 8'h99;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst = 1'b1;
    exp_a_rdata = 8'h00;
    exp_b_rdata = 8'h00;
    mode = 0; delay = 2;
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0010;
    @(posedge clk); #1;
    check("post_reset_grant_a", {30'd0, grant}, 32'd1);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (a_ack) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    a_req = 1'b0;
    check("post_reset_a_ack", {31'd0, got}, 32'd1);
    check("post_reset_a_rdata", {24'd0, a_rdata}, 32'h5A);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk); #1;
      if (b_ack) got = 1'b1;
    end
    b_req = 1'b0;
    check("post_reset_b_ack", {31'd0, got}, 32'd1);
    check("post_reset_b_err", {31'd0, b_err}, 32'd0);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
